mux7_rr_sched: RTL and testbench

//   Round-robin scheduler that shares the 7:1 select mux among 7 requesters.

---
 rtl/mux7_rr_sched_if.sv | 24 ++
 rtl/mux7_rr_sched.sv | 133 +++++++++++++
 tb/tb_mux7_rr_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mux7_rr_sched_if.sv
// Handshake/bus bundle between the seven requesters and the round-robin
// scheduler that drives the shared 7:1 select mux.
//   req   : per-lane request (lane k = req[k])
//   din   : packed lane data, lane k = din[k*WIDTH +: WIDTH]
//   sel   : registered mux select (0..6)
//   gnt   : registered one-hot grant, zero when idle
//   valid : dout carries granted-lane data
//   dout  : registered data of the granted lane
//   busy  : scheduler is in GRANT state
// master = requester side, slave = scheduler side.
interface mux7_rr_sched_if #(
  parameter int WIDTH = 1
);
  logic [6:0]         req;
  logic [7*WIDTH-1:0] din;
  logic [2:0]         sel;
  logic [6:0]         gnt;
  logic               valid;
  logic [WIDTH-1:0]   dout;
  logic               busy;

  modport master (output req, din, input sel, gnt, valid, dout, busy);
  modport slave  (input req, din, output sel, gnt, valid, dout, busy);
endinterface

// File: rtl/mux7_rr_sched.sv
// Round-robin scheduler for a shared 7:1 select mux with bounded grant hold.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : mux7_rr_sched_if.slave (req/din in; sel/gnt/valid/dout/busy out)
// A grant is held while its lane keeps requesting, up to MAX_HOLD cycles,
// then passes to the next requesting lane after it (wrapping 6 -> 0).
// Back-to-back grants never insert an idle cycle.
module mux7_rr_sched #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux7_rr_sched_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sel_q, sel_d;
  logic [6:0]              gnt_q, gnt_d;
  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        dout_q, dout_d;
  logic [2:0]              ptr_q, ptr_d;
  logic [3:0]              hold_q, hold_d;

  logic [6:0][WIDTH-1:0]   lanes;
  logic                    any_req;
  logic                    release_w;
  logic [2:0]              nxt_ptr;

  assign lanes   = bus.din;
  assign any_req = |bus.req;
  // Wrap 6 -> 0 so the pointer never reaches 7.
  assign nxt_ptr = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
  assign release_w = !bus.req[sel_q] || (hold_q == 4'(MAX_HOLD - 1));

  // First requesting lane at or after p, wrapping. Scanning from the far end
  // lets the nearest hit overwrite earlier ones.
  function automatic logic [2:0] pick(input logic [6:0] r, input logic [2:0] p);
    logic [3:0] s;
    logic [2:0] res;
    res = p;
    for (int i = 6; i >= 0; i--) begin
      s = {1'b0, p} + 4'(i);
      if (s >= 4'd7) s = s - 4'd7;
      if (r[s[2:0]]) res = s[2:0];
    end
    return res;
  endfunction

  // State register (all architectural state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_w && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant / pointer / datapath next values.
  always_comb begin
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = pick(bus.req, ptr_q);
          gnt_d   = 7'b1 << sel_d;
          hold_d  = '0;
          valid_d = 1'b1;
          dout_d  = lanes[sel_d];
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d = nxt_ptr;
          if (any_req) begin
            // A lone requester picks itself again here: no gap in gnt.
            sel_d   = pick(bus.req, nxt_ptr);
            gnt_d   = 7'b1 << sel_d;
            hold_d  = '0;
            valid_d = 1'b1;
            dout_d  = lanes[sel_d];
          end else begin
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          hold_d  = hold_q + 4'd1;
          valid_d = 1'b1;
          dout_d  = lanes[sel_q];
        end
      end
      default: ;
    endcase
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
  assign bus.dout  = dout_q;
  assign bus.busy  = (state_q == GRANT);
endmodule

// File: tb/tb_mux7_rr_sched.sv
module tb_mux7_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mux7_rr_sched_if #(.WIDTH(1)) bus0 ();
  mux7_rr_sched_if #(.WIDTH(1)) bus1 ();

  mux7_rr_sched #(.WIDTH(1), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  mux7_rr_sched #(.WIDTH(1), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Sample point: just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus0.req = '0;
    bus1.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus0.din = 7'h7F;
    bus1.din = 7'h7F;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if ({bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout} !== 13'd0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: got sel=%0d gnt=%h valid=%b busy=%b dout=%b, want all 0",
                 c, bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout);
      end
      tests_run++;
      if ({bus1.sel, bus1.gnt, bus1.valid, bus1.busy} !== 12'd0) begin
        tests_failed++;
        $display("FAIL reset_idle_mh1 cyc%0d: got sel=%0d gnt=%h valid=%b busy=%b, want all 0",
                 c, bus1.sel, bus1.gnt, bus1.valid, bus1.busy);
      end
    end
  endtask

  task automatic test_rotation();
    logic [6:0] d;
    logic [6:0] eg;
    d = 7'b0110001;
    bus0.din = d;
    do_reset();
    bus0.req = 7'h7F;
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        eg = 7'b1 << k;
        tests_run++;
        if (bus0.sel !== 3'(k) || bus0.gnt !== eg || bus0.valid !== 1'b1 ||
            bus0.busy !== 1'b1 || bus0.dout !== d[k]) begin
          tests_failed++;
          $display("FAIL rotation lane%0d cyc%0d: got sel=%0d gnt=%h valid=%b busy=%b dout=%b, want sel=%0d gnt=%h valid=1 busy=1 dout=%b",
                   k, c, bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout, k, eg, d[k]);
        end
      end
    end
    tick();
    tests_run++;
    if (bus0.sel !== 3'd0 || bus0.gnt !== 7'h01 || bus0.dout !== 1'b1) begin
      tests_failed++;
      $display("FAIL rotation_wrap: got sel=%0d gnt=%h dout=%b, want sel=0 gnt=01 dout=1",
               bus0.sel, bus0.gnt, bus0.dout);
    end
  endtask

  task automatic test_lone_requester();
    bus0.din = 7'b0000100;
    do_reset();
    bus0.req = 7'b0000100;
    for (int c = 0; c < 12; c++) begin
      tick();
      tests_run++;
      if (bus0.sel !== 3'd2 || bus0.gnt !== 7'h04 || bus0.valid !== 1'b1 ||
          bus0.busy !== 1'b1 || bus0.dout !== 1'b1) begin
        tests_failed++;
        $display("FAIL lone_req cyc%0d: got sel=%0d gnt=%h valid=%b busy=%b dout=%b, want sel=2 gnt=04 valid=1 busy=1 dout=1",
                 c, bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout);
      end
    end
  endtask

  task automatic test_early_release();
    bus0.din = 7'b0100000;
    do_reset();
    bus0.req = 7'b0001000;
    tick();
    tests_run++;
    if (bus0.sel !== 3'd3 || bus0.gnt !== 7'h08 || bus0.dout !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_rel_first: got sel=%0d gnt=%h dout=%b, want sel=3 gnt=08 dout=0",
               bus0.sel, bus0.gnt, bus0.dout);
    end
    bus0.req = 7'b0101000;  // lane 5 arrives, must not disturb lane 3
    tick();
    tests_run++;
    if (bus0.sel !== 3'd3 || bus0.gnt !== 7'h08) begin
      tests_failed++;
      $display("FAIL early_rel_hold: got sel=%0d gnt=%h, want sel=3 gnt=08", bus0.sel, bus0.gnt);
    end
    bus0.req = 7'b0100000;
    tick();
    tests_run++;
    if (bus0.sel !== 3'd5 || bus0.gnt !== 7'h20 || bus0.valid !== 1'b1 || bus0.dout !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_rel_switch: got sel=%0d gnt=%h valid=%b dout=%b, want sel=5 gnt=20 valid=1 dout=1",
               bus0.sel, bus0.gnt, bus0.valid, bus0.dout);
    end
    bus0.req = 7'b0000000;
    tick();
    tests_run++;
    if (bus0.sel !== 3'd5 || bus0.gnt !== 7'h00 || bus0.valid !== 1'b0 ||
        bus0.busy !== 1'b0 || bus0.dout !== 1'b1) begin
      tests_failed++;
      $display("FAIL go_idle: got sel=%0d gnt=%h valid=%b busy=%b dout=%b, want sel=5 gnt=00 valid=0 busy=0 dout=1",
               bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout);
    end
  endtask

  task automatic test_async_reset();
    bus0.din = 7'b1000000;
    do_reset();
    bus0.req = 7'b1000000;
    tick();
    tests_run++;
    if (bus0.sel !== 3'd6 || bus0.gnt !== 7'h40 || bus0.dout !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_pre: got sel=%0d gnt=%h dout=%b, want sel=6 gnt=40 dout=1",
               bus0.sel, bus0.gnt, bus0.dout);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout} !== 13'd0) begin
      tests_failed++;
      $display("FAIL arst_now: got sel=%0d gnt=%h valid=%b busy=%b dout=%b, want all 0",
               bus0.sel, bus0.gnt, bus0.valid, bus0.busy, bus0.dout);
    end
    bus0.req = 7'h41;
    #1 rst = 1'b0;
    tick();
    tests_run++;
    if (bus0.sel !== 3'd0 || bus0.gnt !== 7'h01 || bus0.valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_ptr0: got sel=%0d gnt=%h valid=%b, want sel=0 gnt=01 valid=1",
               bus0.sel, bus0.gnt, bus0.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] es;
    logic [6:0] eg;
    bus1.din = 7'b1000000;
    do_reset();
    bus1.req = 7'b1000001;
    for (int c = 0; c < 8; c++) begin
      tick();
      es = (c % 2 == 0) ? 3'd0 : 3'd6;
      eg = (c % 2 == 0) ? 7'h01 : 7'h40;
      tests_run++;
      if (bus1.sel !== es || bus1.gnt !== eg || bus1.valid !== 1'b1 ||
          bus1.busy !== 1'b1 || bus1.dout !== es[1]) begin
        tests_failed++;
        $display("FAIL mh1_alt cyc%0d: got sel=%0d gnt=%h valid=%b busy=%b dout=%b, want sel=%0d gnt=%h valid=1 busy=1 dout=%b",
                 c, bus1.sel, bus1.gnt, bus1.valid, bus1.busy, bus1.dout, es, eg, es[1]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus0.req = '0;
    bus1.req = '0;
    bus0.din = '0;
    bus1.din = '0;
    test_reset();
    test_rotation();
    test_lone_requester();
    test_early_release();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
